// File: rtl/ram_true_dual_pipe.sv
// True dual-port, byte-writable RAM with a 1- or 2-stage read pipeline and a zeroing pass after every reset.
// Define RAM_PARITY_EN to store and check one even-parity bit per byte lane (adds par_err_a/par_err_b).
module ram_true_dual_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0,
    parameter int DISTR      = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             init_busy,
    input  logic                             ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]            addra,
    input  logic [DATA_WIDTH-1:0]            dia,
    output logic [DATA_WIDTH-1:0]            doa,
    output logic                             doa_valid,
    input  logic                             enb,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] web,
    input  logic [ADDR_WIDTH-1:0]            addrb,
    input  logic [DATA_WIDTH-1:0]            dib,
    output logic [DATA_WIDTH-1:0]            dob,
    output logic                             dob_valid,
    output logic                             collision,
    output logic [1:0]                       addr_err
`ifdef RAM_PARITY_EN
    ,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] par_err_a,
    output logic [DATA_WIDTH/BYTE_WIDTH-1:0] par_err_b
`endif
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef RAM_PARITY_EN
    localparam int LW = BYTE_WIDTH + 1;
`else
    localparam int LW = BYTE_WIDTH;
`endif
    localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [IW-1:0]       LAST_IDX = IW'(DEPTH - 1);

    genvar gi, gj;

    typedef enum logic {S_INIT, S_RUN} state_t;
    state_t        state_reg, state_next;
    logic [IW-1:0] init_cnt_reg, init_cnt_next;
    logic          init_busy_reg, init_busy_next;
    logic          run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_INIT;
            init_cnt_reg  <= '0;
            init_busy_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            init_cnt_reg  <= init_cnt_next;
            init_busy_reg <= init_busy_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        if (state_reg == S_INIT) begin
            init_cnt_next = init_cnt_reg + 1'b1;
            if (init_cnt_reg == LAST_IDX) begin
                state_next    = S_RUN;
                init_cnt_next = '0;
            end
        end
    end

    // init_busy lags the state by one edge so it drops exactly when the first access can land.
    always_comb begin
        run            = (state_reg == S_RUN);
        init_busy_next = (state_reg == S_INIT);
    end

    assign init_busy = init_busy_reg;

    logic [1:0]                 en_w, acc, in_rng, dv;
    logic [1:0][NB-1:0]         we_w, wr;
    logic [1:0][ADDR_WIDTH-1:0] addr_w;
    logic [1:0][DATA_WIDTH-1:0] di_w, do_w;
    logic [1:0][IW-1:0]         idx;
    logic [1:0][NB-1:0][LW-1:0] wd, q_w, d_w;
    logic [1:0]                 v1_reg, err_reg;
    logic                       collision_reg;

    assign en_w   = {enb, ena};
    assign we_w   = {web, wea};
    assign addr_w = {addrb, addra};
    assign di_w   = {dib, dia};

    for (gi = 0; gi < 2; gi++) begin : g_port
        assign acc[gi]    = run & en_w[gi];
        assign in_rng[gi] = {1'b0, addr_w[gi]} < DEPTH_W;
        assign idx[gi]    = run ? addr_w[gi][IW-1:0] : init_cnt_reg;
        for (gj = 0; gj < NB; gj++) begin : g_lane
            logic [BYTE_WIDTH-1:0] byte_w;
            assign byte_w = di_w[gi][gj*BYTE_WIDTH +: BYTE_WIDTH];
            // The zeroing pass drives port A's write path.
            assign wr[gi][gj] = run ? (acc[gi] & in_rng[gi] & we_w[gi][gj]) : (gi == 0);
`ifdef RAM_PARITY_EN
            assign wd[gi][gj] = run ? {^byte_w, byte_w} : '0;
`else
            assign wd[gi][gj] = run ? byte_w : '0;
`endif
            assign do_w[gi][gj*BYTE_WIDTH +: BYTE_WIDTH] = d_w[gi][gj][BYTE_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg        <= '0;
            err_reg       <= '0;
            collision_reg <= 1'b0;
        end else begin
            v1_reg        <= acc;
            err_reg       <= acc & ~in_rng;
            collision_reg <= (&acc) && (&in_rng) && (|we_w[0]) && (|we_w[1])
                             && (addr_w[0] == addr_w[1]);
        end
    end

    // One storage array per byte lane; port A is written last so its lanes win a collision.
    for (gj = 0; gj < NB; gj++) begin : g_mem
        logic [1:0][LW-1:0] rd_lane;
        if (DISTR != 0) begin : g_distr
            (* ram_style = "distributed" *) logic [LW-1:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr[1][gj]) mem[idx[1]] <= wd[1][gj];
                if (wr[0][gj]) mem[idx[0]] <= wd[0][gj];
            end
            assign rd_lane[0] = mem[idx[0]];
            assign rd_lane[1] = mem[idx[1]];
        end else begin : g_block
            (* ram_style = "block" *) logic [LW-1:0] mem [DEPTH];
            always_ff @(posedge clk) begin
                if (wr[1][gj]) mem[idx[1]] <= wd[1][gj];
                if (wr[0][gj]) mem[idx[0]] <= wd[0][gj];
            end
            assign rd_lane[0] = mem[idx[0]];
            assign rd_lane[1] = mem[idx[1]];
        end

        // Write-first only bypasses this port's own write; the other port always sees old data.
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [LW-1:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= '0;
                end else if (acc[gi]) begin
                    if (!in_rng[gi])
                        q_reg <= '0;
                    else if (RDW_MODE != 0 && wr[gi][gj])
                        q_reg <= wd[gi][gj];
                    else
                        q_reg <= rd_lane[gi];
                end
            end
            assign q_w[gi][gj] = q_reg;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic [1:0]                 v2_reg;
        logic [1:0][NB-1:0][LW-1:0] d2_reg;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v2_reg <= '0;
                d2_reg <= '0;
            end else begin
                v2_reg <= v1_reg;
                for (int p = 0; p < 2; p++)
                    if (v1_reg[p]) d2_reg[p] <= q_w[p];
            end
        end
        assign dv  = v2_reg;
        assign d_w = d2_reg;
    end else begin : g_lat1
        assign dv  = v1_reg;
        assign d_w = q_w;
    end

    assign doa       = do_w[0];
    assign dob       = do_w[1];
    assign doa_valid = dv[0];
    assign dob_valid = dv[1];
    assign collision = collision_reg;
    assign addr_err  = err_reg;

`ifdef RAM_PARITY_EN
    for (gj = 0; gj < NB; gj++) begin : g_par
        assign par_err_a[gj] = dv[0] & (^d_w[0][gj]);
        assign par_err_b[gj] = dv[1] & (^d_w[1][gj]);
    end
`endif

endmodule

// File: doc/ram_true_dual_pipe.md
# ram_true_dual_pipe

Single-clock, true dual-port RAM with per-byte write enables, a selectable read pipeline depth, a defined read-during-write mode and a post-reset zeroing sequencer. Each port returns a data-valid strobe. The block flags write/write address collisions and out-of-range addresses. It replaces the bare dual-port RAM in action-side buffers, where both ports share one clock domain and software-visible state must come up cleared after every reset, not only at bitstream load.

## Interface
- DATA_WIDTH, 64, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH lanes.
- ADDR_WIDTH, 9, address width.
- DEPTH, 2**ADDR_WIDTH, number of words; any value 2..2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data).
- DISTR, 0, 1 = distributed RAM style, 0 = block RAM style.
- clk  in  1  sole clock; all ports are synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- init_busy  out  1  high during reset and while memory is being zeroed.
- ena / enb  in  1  port access enable.
- wea / web  in  NB  byte write enables; all zero = read.
- addra / addrb  in  ADDR_WIDTH  word address.
- dia / dib  in  DATA_WIDTH  write data.
- doa / dob  out  DATA_WIDTH  read data.
- doa_valid / dob_valid  out  1  read data valid strobe.
- collision  out  1  one-cycle pulse: both ports wrote the same address.
- addr_err  out  2  one-cycle pulse per port (bit 0 = A, bit 1 = B): enabled access with addr >= DEPTH.

## Operation
- Reset values: doa/dob = 0, doa_valid/dob_valid = 0, collision = 0, addr_err = 0, init_busy = 1.
- State machine states:
  - INIT: entered on rst assertion and held while rst is high. After release, writes zero to addresses 0..DEPTH-1, one address per cycle, using an internal counter. Moves to RUN after writing address DEPTH-1.
  - RUN: normal operation.
- During INIT, ena/enb and all write enables are ignored; no valid strobes, collision or addr_err are produced.
- Reset asserted mid-operation: the pipeline is flushed, valids drop asynchronously, and zeroing restarts from address 0.
- Every enabled access, read or write, produces exactly one valid strobe on its port after RD_LATENCY cycles.
- Same-port write: doa/dob returns pre-write data when RDW_MODE = 0. With RDW_MODE = 1 it returns merged post-write data: written lanes new, others old.
- Cross-port read of an address written by the other port in the same cycle returns the old data.
- Both ports write the same address in the same cycle:
  - lanes enabled on A take dia;
  - lanes enabled only on B take dib;
  - collision pulses.
- Out-of-range access:
  - the write is dropped;
  - read data is 0;
  - the valid strobe is still produced;
  - the matching addr_err bit pulses.
- doa/dob hold their last value when no strobe is pending.

## Timing
- Address and enable presented at edge T; data and valid appear at edge T+RD_LATENCY.
- With RD_LATENCY = 2 the extra output register stage is enabled only when a valid is advancing.
- Throughput is one access per port per cycle, with no stalls.
- collision and addr_err assert at edge T+1.
- init_busy falls at edge R+DEPTH, where R is the first clk edge after rst deasserts. The first accepted access is at edge R+DEPTH.

## Configuration
- RAM_PARITY_EN defined:
  - one even-parity bit is stored per byte lane and written with its lane;
  - zeroing writes parity 0;
  - on read, parity is checked and outputs par_err_a and par_err_b (each NB bits wide) assert alongside the corresponding valid;
  - out-of-range reads report no parity error.
- RAM_PARITY_EN undefined: no parity storage and no par_err ports.

## Test plan
- Reset, release, DEPTH = 16: init_busy stays high for 16 cycles. A read of each address afterwards returns 0 with valid at T+1.
- Write 0x1122334455667788 at address 5 with wea = 0x0F, then read address 5. The result is 0x0000000055667788 at RD_LATENCY 1 and at RD_LATENCY 2, each with correct valid spacing.
- Same-port write of 0xAA.. over 0x55.. at one address. doa returns 0x55.. with RDW_MODE = 0 and 0xAA.. with RDW_MODE = 1.
- Both ports write address 3 in the same cycle: A with 0x0F lanes, B with 0xFF lanes. Memory holds A data in lanes 0-3 and B data in lanes 4-7; collision pulses at T+1.
- DEPTH = 12: an access at address 13 on port B drops the write, returns 0 with valid, and sets addr_err = 2'b10.
- Assert rst mid-stream with valids pending. Valids clear immediately, zeroing restarts, and the prior data reads 0 afterwards.
